// File: rtl/effect_pkg.sv
// Shared definitions for the effect chain sequencer and the effects engine:
// effect codes, sequencer FSM states and the default frame size.
package effect_pkg;

  localparam int PIXELS_DEFAULT = 900;
  localparam int EFF_CODE_W     = 3;

  localparam logic [EFF_CODE_W-1:0] EFF_COPY    = 3'd0;
  localparam logic [EFF_CODE_W-1:0] EFF_INVERT  = 3'd1;
  localparam logic [EFF_CODE_W-1:0] EFF_GRAY    = 3'd2;
  localparam logic [EFF_CODE_W-1:0] EFF_BLUR    = 3'd3;
  localparam logic [EFF_CODE_W-1:0] EFF_SHARPEN = 3'd4;
  localparam logic [EFF_CODE_W-1:0] EFF_EDGE    = 3'd5;
  localparam logic [EFF_CODE_W-1:0] EFF_SEPIA   = 3'd6;
  localparam logic [EFF_CODE_W-1:0] EFF_THRESH  = 3'd7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    GAP   = 3'd3,
    FIN   = 3'd4,
    ABORT = 3'd5
  } seq_state_t;

endpackage

// File: rtl/effect_cmd_fifo.sv
// Command queue for the sequencer: DEPTH x W synchronous FIFO.
// Read data is the registered head entry, so a pop only ever sees data pushed
// on an earlier edge. Flush empties the queue on the next edge.
module effect_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage array; entries are only meaningful between rptr and wptr.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop_ok) begin
        rptr <= rptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/effect_chain_sequencer.sv
// Runs a queued chain of effect passes over one frame, ping-ponging two frame
// buffers so each pass reads the previous pass's output. Drives the effects
// engine start/select handshake, watches for the last pixel write, aborts a
// stuck pass via a watchdog and reports the bank holding the final image.
module effect_chain_sequencer
  import effect_pkg::*;
#(
  parameter int PIXELS = PIXELS_DEFAULT,
  parameter int DEPTH  = 8,
  parameter int EFF_W  = 3,
  parameter int WDOG   = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  input  logic [EFF_W-1:0]             cmd_eff,
  output logic                         cmd_ready,
  input  logic                         go,
  output logic                         eff_start,
  output logic [EFF_W-1:0]             eff_sel,
  input  logic                         eff_done,
  input  logic [$clog2(PIXELS)-1:0]    eff_waddr,
  output logic                         src_bank,
  output logic                         dst_bank,
  output logic                         busy,
  output logic                         chain_done,
  output logic                         result_bank,
  output logic [$clog2(DEPTH+1)-1:0]   pass_cnt,
  output logic                         err
);

  localparam int AW  = $clog2(PIXELS);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int WDW = $clog2(PIXELS + WDOG + 1);

  localparam logic [AW-1:0]  LAST_ADDR = AW'(PIXELS - 1);
  localparam logic [WDW-1:0] WD_LIMIT  = WDW'(PIXELS + WDOG - 1);

  seq_state_t       state;
  seq_state_t       state_next;

  logic             push;
  logic             pop;
  logic             flush;
  logic [EFF_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  logic [WDW-1:0]   wd_cnt;
  logic             wd_expired;
  logic             pass_done;
  logic             go_ok;
  logic             err_go_q;

  assign push       = cmd_valid && cmd_ready;
  assign pass_done  = eff_done && (eff_waddr == LAST_ADDR);
  assign wd_expired = (wd_cnt == WD_LIMIT);
  assign go_ok      = (state == IDLE) && go && ((fifo_count != '0) || push);

  effect_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (EFF_W)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata (cmd_eff),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: one LOAD/RUN/GAP round per queued effect, then FIN or ABORT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go_ok) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN: begin
        if (pass_done) begin
          state_next = GAP;
        end else if (wd_expired) begin
          state_next = ABORT;
        end
      end
      GAP:     state_next = fifo_empty ? FIN : LOAD;
      FIN:     state_next = IDLE;
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state; the empty-go error is a registered pulse.
  always_comb begin
    eff_start  = (state == RUN);
    busy       = (state != IDLE);
    cmd_ready  = (state == IDLE) && !fifo_full;
    chain_done = (state == FIN);
    err        = (state == ABORT) || err_go_q;
    pop        = (state == LOAD);
    flush      = (state == ABORT);
    dst_bank   = ~src_bank;
  end

  // Chain datapath: effect select, bank ping-pong, pass count, watchdog, result bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      eff_sel     <= EFF_W'(EFF_COPY);
      src_bank    <= 1'b0;
      pass_cnt    <= '0;
      result_bank <= 1'b0;
      wd_cnt      <= '0;
      err_go_q    <= 1'b0;
    end else begin
      err_go_q <= (state == IDLE) && go && (fifo_count == '0) && !push;
      case (state)
        IDLE: begin
          if (go_ok) begin
            src_bank <= 1'b0;
            pass_cnt <= '0;
          end
        end
        LOAD: begin
          eff_sel <= fifo_rdata;
          wd_cnt  <= '0;
        end
        RUN: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (pass_done) begin
            pass_cnt <= pass_cnt + 1'b1;
          end
        end
        GAP: begin
          src_bank <= ~src_bank;
          if (fifo_empty) begin
            result_bank <= ~src_bank;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_effect_chain_sequencer.sv
// Self-checking bench for effect_chain_sequencer. A schedule model builds the
// expected cycle-by-cycle outputs of a whole chain from the pass lengths the
// engine model will produce; a negedge compare process checks every cycle.
module tb_effect_chain_sequencer;
  import effect_pkg::*;

  localparam int PIXELS = 900;
  localparam int DEPTH  = 8;
  localparam int EFF_W  = 3;
  localparam int WDOG   = 64;
  localparam int AW     = $clog2(PIXELS);
  localparam int CW     = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [EFF_W-1:0] cmd_eff = '0;
  logic             go = 1'b0;
  logic             eff_done = 1'b0;
  logic [AW-1:0]    eff_waddr = '0;
  logic             cmd_ready;
  logic             eff_start;
  logic [EFF_W-1:0] eff_sel;
  logic             src_bank;
  logic             dst_bank;
  logic             busy;
  logic             chain_done;
  logic             result_bank;
  logic [CW-1:0]    pass_cnt;
  logic             err;

  int total = 0;
  int bad   = 0;

  int eng_len       = 20;
  bit eng_hang      = 1'b0;
  int eng_false_at  = 0;
  bit eng_idle_done = 1'b0;
  int eng_cnt       = 0;

  typedef struct {
    bit busy;
    bit start;
    int sel;
    int src;
    bit done;
    bit err;
    int pcnt;
    bit chk_res;
    int res;
  } exp_t;

  effect_chain_sequencer #(
    .PIXELS (PIXELS),
    .DEPTH  (DEPTH),
    .EFF_W  (EFF_W),
    .WDOG   (WDOG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_eff     (cmd_eff),
    .cmd_ready   (cmd_ready),
    .go          (go),
    .eff_start   (eff_start),
    .eff_sel     (eff_sel),
    .eff_done    (eff_done),
    .eff_waddr   (eff_waddr),
    .src_bank    (src_bank),
    .dst_bank    (dst_bank),
    .busy        (busy),
    .chain_done  (chain_done),
    .result_bank (result_bank),
    .pass_cnt    (pass_cnt),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [EFF_W-1:0] e, input logic g, input logic r);
    @(posedge clk);
    #1;
    cmd_valid = v;
    cmd_eff   = e;
    go        = g;
    rst       = r;
  endtask

  task automatic runChain(input int budget, input int noise, output int busy_cyc,
                          output int start_cyc, output bit saw_done, output bit saw_err);
    bit finished;
    finished  = 1'b0;
    busy_cyc  = 0;
    start_cyc = 0;
    saw_done  = 1'b0;
    saw_err   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (i < noise) applyStimulus(1'b1, EFF_BLUR, 1'b1, 1'b0);
      else           applyStimulus(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      if (busy)       busy_cyc++;
      if (eff_start)  start_cyc++;
      if (chain_done) saw_done = 1'b1;
      if (err)        saw_err = 1'b1;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) checkOutput("chain_timeout", 0, 1);
  endtask

  function automatic exp_t idleRec(input int s, input int p, input int r, input bit e);
    exp_t x;
    x.busy = 0; x.start = 0; x.sel = 0; x.src = s; x.done = 0;
    x.err = e;  x.pcnt = p;  x.chk_res = 1; x.res = r;
    return x;
  endfunction

  function automatic exp_t busyRec(input bit st, input int sel, input int s, input int p);
    exp_t x;
    x.busy = 1; x.start = st; x.sel = sel; x.src = s; x.done = 0;
    x.err = 0;  x.pcnt = p;   x.chk_res = 0; x.res = 0;
    return x;
  endfunction

  // Engine model: counts cycles of eff_start and finishes each pass after eng_len
  // cycles with the final write at address PIXELS-1.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (eff_start === 1'b1) begin
        eng_cnt++;
        if (eng_hang) begin
          eff_waddr = AW'((eng_cnt - 1) % PIXELS);
          eff_done  = 1'b0;
        end else begin
          eff_waddr = AW'(PIXELS - eng_len + eng_cnt - 1);
          eff_done  = (eng_cnt == eng_len) || (eng_cnt == eng_false_at);
        end
      end else begin
        eng_cnt   = 0;
        eff_done  = eng_idle_done;
        eff_waddr = eng_idle_done ? AW'(PIXELS - 1) : '0;
      end
    end
  end

  // Compare process with the chain schedule model.
  initial begin
    exp_t cur;
    exp_t sched[$];
    int   mq[$];
    bit   model_on;
    bit   go_err;
    int   m_src, m_pcnt, m_res, n;
    model_on = 1'b0;
    m_src = 0; m_pcnt = 0; m_res = 0;
    cur = idleRec(0, 0, 0, 0);
    forever begin
      @(negedge clk);
      if (model_on) begin
        checkOutput("busy", int'(busy), int'(cur.busy));
        checkOutput("eff_start", int'(eff_start), int'(cur.start));
        checkOutput("chain_done", int'(chain_done), int'(cur.done));
        checkOutput("err", int'(err), int'(cur.err));
        checkOutput("src_bank", int'(src_bank), cur.src);
        checkOutput("dst_bank", int'(dst_bank), 1 - cur.src);
        checkOutput("pass_cnt", int'(pass_cnt), cur.pcnt);
        checkOutput("cmd_ready", int'(cmd_ready), int'(!cur.busy && mq.size() < DEPTH));
        if (cur.start)   checkOutput("eff_sel", int'(eff_sel), cur.sel);
        if (cur.chk_res) checkOutput("result_bank", int'(result_bank), cur.res);
      end
      go_err = 1'b0;
      if (rst) begin
        sched.delete();
        mq.delete();
        m_src = 0; m_pcnt = 0; m_res = 0;
        cur = idleRec(0, 0, 0, 0);
        model_on = 1'b1;
      end else if (model_on) begin
        if (!cur.busy) begin
          if (cmd_valid && mq.size() < DEPTH) mq.push_back(int'(cmd_eff));
          if (go) begin
            if (mq.size() == 0) begin
              go_err = 1'b1;
            end else begin
              n = mq.size();
              for (int k = 0; k < n; k++) begin
                sched.push_back(busyRec(0, 0, k % 2, k));
                if (eng_hang) begin
                  exp_t ab;
                  for (int c = 0; c < PIXELS + WDOG; c++) sched.push_back(busyRec(1, mq[k], 0, 0));
                  ab = busyRec(0, 0, 0, 0);
                  ab.err = 1;
                  sched.push_back(ab);
                  break;
                end
                for (int c = 0; c < eng_len; c++) sched.push_back(busyRec(1, mq[k], k % 2, k));
                sched.push_back(busyRec(0, 0, k % 2, k + 1));
                if (k == n - 1) begin
                  exp_t fin;
                  fin = busyRec(0, 0, n % 2, n);
                  fin.done = 1; fin.chk_res = 1; fin.res = n % 2;
                  sched.push_back(fin);
                end
              end
              mq.delete();
            end
          end
        end
        if (sched.size() > 0) begin
          cur = sched.pop_front();
          m_src  = cur.src;
          m_pcnt = cur.pcnt;
          if (cur.done) m_res = cur.res;
        end else begin
          cur = idleRec(m_src, m_pcnt, m_res, go_err);
        end
      end
    end
  end

  // Directed stimulus with hand-computed literal expectations.
  initial begin
    int bc, sc;
    bit sd, se;
    logic [EFF_W-1:0] codes [9];
    codes = '{EFF_INVERT, EFF_GRAY, EFF_BLUR, EFF_SHARPEN, EFF_EDGE, EFF_SEPIA, EFF_THRESH, EFF_COPY, EFF_EDGE};

    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_dst", int'(dst_bank), 1);
    checkOutput("reset_ready", int'(cmd_ready), 1);
    checkOutput("reset_result", int'(result_bank), 0);

    $display("[TB] test 1: single full-frame pass");
    eng_len = PIXELS;
    applyStimulus(1'b1, EFF_GRAY, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    runChain(2000, 0, bc, sc, sd, se);
    checkOutput("t1_cycles", bc, 903);
    checkOutput("t1_start_cycles", sc, 900);
    checkOutput("t1_done_seen", int'(sd), 1);
    checkOutput("t1_result", int'(result_bank), 1);
    checkOutput("t1_pass_cnt", int'(pass_cnt), 1);

    $display("[TB] test 2: three-pass chain, stray done pulses, busy noise");
    eng_len = 20;
    eng_false_at = 5;
    eng_idle_done = 1'b1;
    applyStimulus(1'b1, EFF_INVERT, 1'b0, 1'b0);
    eng_idle_done = 1'b0;
    applyStimulus(1'b1, EFF_GRAY, 1'b0, 1'b0);
    applyStimulus(1'b1, EFF_BLUR, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    runChain(500, 10, bc, sc, sd, se);
    eng_false_at = 0;
    checkOutput("t2_cycles", bc, 67);
    checkOutput("t2_result", int'(result_bank), 1);
    checkOutput("t2_pass_cnt", int'(pass_cnt), 3);

    $display("[TB] test 5: watchdog abort");
    eng_hang = 1'b1;
    applyStimulus(1'b1, EFF_EDGE, 1'b0, 1'b0);
    applyStimulus(1'b1, EFF_SEPIA, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    runChain(2000, 0, bc, sc, sd, se);
    eng_hang = 1'b0;
    checkOutput("t5_start_cycles", sc, 964);
    checkOutput("t5_err_seen", int'(se), 1);
    checkOutput("t5_done_seen", int'(sd), 0);
    checkOutput("t5_result_kept", int'(result_bank), 1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t5_flushed_err", int'(err), 1);

    $display("[TB] test 3: go on empty queue, then push+go together");
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t3_err", int'(err), 1);
    checkOutput("t3_busy", int'(busy), 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t3_err_clear", int'(err), 0);
    applyStimulus(1'b1, EFF_SEPIA, 1'b1, 1'b0);
    runChain(500, 0, bc, sc, sd, se);
    checkOutput("t3_cycles", bc, 23);
    checkOutput("t3_pass_cnt", int'(pass_cnt), 1);

    $display("[TB] test 4: overfill the queue");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, codes[i], 1'b0, 1'b0);
    applyStimulus(1'b1, codes[8], 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t4_ready_full", int'(cmd_ready), 0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    runChain(1000, 0, bc, sc, sd, se);
    checkOutput("t4_cycles", bc, 177);
    checkOutput("t4_pass_cnt", int'(pass_cnt), 8);
    checkOutput("t4_result", int'(result_bank), 0);

    $display("[TB] test 6: reset in the middle of pass 2");
    applyStimulus(1'b1, EFF_INVERT, 1'b0, 1'b0);
    applyStimulus(1'b1, EFF_GRAY, 1'b0, 1'b0);
    applyStimulus(1'b1, EFF_BLUR, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 33; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t6_pass2_start", int'(eff_start), 1);
    checkOutput("t6_pass2_sel", int'(eff_sel), 2);
    checkOutput("t6_pass2_src", int'(src_bank), 1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t6_busy", int'(busy), 0);
    checkOutput("t6_start", int'(eff_start), 0);
    checkOutput("t6_src", int'(src_bank), 0);
    checkOutput("t6_pass_cnt", int'(pass_cnt), 0);
    checkOutput("t6_result", int'(result_bank), 0);
    checkOutput("t6_err", int'(err), 0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t6_go_empty_err", int'(err), 1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
